// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//
// This interface bundles every signal between the hazard scoreboard and the
// pipeline control. The clock and reset are not part of it.
//
// Decode side (pipeline -> scoreboard):
//   valid_de, rs1_de, rs2_de, rs1_use_de, rs2_use_de, rd_de, RUWr_de, load_de
// Resolution / memory (pipeline -> scoreboard):
//   br_taken_ex, mem_ready
// Hazard controls (scoreboard -> pipeline registers):
//   stall_fe, stall_de, flush_de, freeze
// Stage destinations (scoreboard -> forwarding unit / control):
//   rd_ex, load_ex, rd_me, RUWr_me, rd_wb, RUWr_wb
// Statistics (scoreboard -> observer), present only with HAZARD_STATS_EN:
//   stall_cnt
//
// Modports:
//   master : the pipeline side, which drives decode and memory status
//   slave  : the scoreboard side
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic             valid_de;
    logic [REG_W-1:0] rs1_de;
    logic [REG_W-1:0] rs2_de;
    logic             rs1_use_de;
    logic             rs2_use_de;
    logic [REG_W-1:0] rd_de;
    logic             RUWr_de;
    logic             load_de;
    logic             br_taken_ex;
    logic             mem_ready;

    logic             stall_fe;
    logic             stall_de;
    logic             flush_de;
    logic             freeze;
    logic [REG_W-1:0] rd_ex;
    logic             load_ex;
    logic [REG_W-1:0] rd_me;
    logic             RUWr_me;
    logic [REG_W-1:0] rd_wb;
    logic             RUWr_wb;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output valid_de, rs1_de, rs2_de, rs1_use_de, rs2_use_de,
               rd_de, RUWr_de, load_de, br_taken_ex, mem_ready,
        input  stall_fe, stall_de, flush_de, freeze,
               rd_ex, load_ex, rd_me, RUWr_me, rd_wb, RUWr_wb
`ifdef HAZARD_STATS_EN
               , stall_cnt
`endif
    );

    modport slave (
        input  valid_de, rs1_de, rs2_de, rs1_use_de, rs2_use_de,
               rd_de, RUWr_de, load_de, br_taken_ex, mem_ready,
        output stall_fe, stall_de, flush_de, freeze,
               rd_ex, load_ex, rd_me, RUWr_me, rd_wb, RUWr_wb
`ifdef HAZARD_STATS_EN
               , stall_cnt
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// This module tracks the destination register of the instruction in each of
// the EX, ME and WB stages of the 5-stage RISC-V pipeline. It generates the
// hazards that the forwarding unit cannot resolve:
//   - load-use stall : a decode instruction reads the register that a load in
//                      EX is about to write. The stall is one cycle, and FU
//                      then forwards the value from ME.
//   - taken-branch flush : kills the instruction in IF-DE, and EX gets a bubble.
//   - memory freeze : every pipeline register holds while data memory is busy.
// The priority order is freeze > flush > load-use stall.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset. It clears every stage entry. While
//          it is asserted, all hazard outputs are forced low.
//   bus  : hazard_scoreboard_if.slave (the decode inputs, the hazard controls
//          and the stage destinations)
//
// Optional feature: define HAZARD_STATS_EN to add the parameter CNT_W and the
// saturating stall_cnt output. stall_cnt counts the cycles that have stall_de
// or freeze asserted.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    // Each stage entry stores its flags already masked by the valid bit, and
    // stores rd as 0 for an invalid entry. With this encoding the outputs come
    // straight from the flops, and no separate valid bit has to be kept.
    logic [REG_W-1:0] ex_rd;
    logic             ex_wr;
    logic             ex_ld;
    logic [REG_W-1:0] me_rd;
    logic             me_wr;
    logic [REG_W-1:0] wb_rd;
    logic             wb_wr;

    logic src1_hit;
    logic src2_hit;
    logic load_use;
    logic freeze_c;
    logic flush_c;
    logic stall_c;

    // ---- Hazard detection (combinational, same cycle) ----
    always_comb begin
        src1_hit = bus.rs1_use_de && (bus.rs1_de == ex_rd);
        src2_hit = bus.rs2_use_de && (bus.rs2_de == ex_rd);
        // A zero index in EX means either x0 or an invalid entry, so x0 can
        // never produce a hazard.
        load_use = ex_ld && ex_wr && (ex_rd != '0) && bus.valid_de
                   && (src1_hit || src2_hit);

        freeze_c = !rst && !bus.mem_ready;
        flush_c  = !rst && bus.br_taken_ex && bus.mem_ready;
        stall_c  = !rst && load_use && !bus.br_taken_ex && bus.mem_ready;
    end

    assign bus.freeze   = freeze_c;
    assign bus.flush_de = flush_c;
    assign bus.stall_de = stall_c;
    assign bus.stall_fe = stall_c;

    // ---- Stage entries: DE -> EX -> ME -> WB ----
    // A freeze holds every entry. While the entries hold, a pending load-use
    // condition stays visible, and the stall asserts in the first cycle after
    // mem_ready returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd <= '0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
            me_rd <= '0;
            me_wr <= 1'b0;
            wb_rd <= '0;
            wb_wr <= 1'b0;
        end else if (!freeze_c) begin
            wb_rd <= me_rd;
            wb_wr <= me_wr;
            me_rd <= ex_rd;
            me_wr <= ex_wr;
            if (flush_c || stall_c || !bus.valid_de) begin
                ex_rd <= '0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_rd <= bus.rd_de;
                ex_wr <= bus.RUWr_de;
                ex_ld <= bus.load_de;
            end
        end
    end

    assign bus.rd_ex   = ex_rd;
    assign bus.load_ex = ex_ld;
    assign bus.rd_me   = me_rd;
    assign bus.RUWr_me = me_wr;
    assign bus.rd_wb   = wb_rd;
    assign bus.RUWr_wb = wb_wr;

`ifdef HAZARD_STATS_EN
    // ---- Stall statistics ----
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_c || freeze_c) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int REG_W = 5;
`ifdef HAZARD_STATS_EN
    localparam int CNT_W = 3;
`endif

    logic clk;
    logic rst;

`ifdef HAZARD_STATS_EN
    hazard_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
    hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`else
    hazard_scoreboard_if #(.REG_W(REG_W)) bus ();
    hazard_scoreboard #(.REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. Each slot is one in-flight instruction: 0=EX, 1=ME, 2=WB.
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } instr_t;

    typedef struct {
        bit        stall_fe, stall_de, flush_de, freeze;
        bit [4:0]  rd_ex;
        bit        load_ex;
        bit [4:0]  rd_me;
        bit        ruwr_me;
        bit [4:0]  rd_wb;
        bit        ruwr_wb;
        int        cnt;
    } exp_t;

    instr_t pipe [3];
    int     cnt_m;
    exp_t   exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle of stimulus. The expected outputs for this cycle are
    // pushed to the queue, and then the model advances over the coming edge.
    task automatic cycle(input bit r, input bit v,
                         input bit [4:0] s1, input bit [4:0] s2,
                         input bit u1, input bit u2,
                         input bit [4:0] d, input bit w, input bit l,
                         input bit br, input bit mr, input bit push);
        exp_t   e;
        bit     lu;
        instr_t nxt [3];
        @(negedge clk);
        rst             = r;
        bus.valid_de    = v;
        bus.rs1_de      = s1;
        bus.rs2_de      = s2;
        bus.rs1_use_de  = u1;
        bus.rs2_use_de  = u2;
        bus.rd_de       = d;
        bus.RUWr_de     = w;
        bus.load_de     = l;
        bus.br_taken_ex = br;
        bus.mem_ready   = mr;

        e.rd_ex   = pipe[0].valid ? pipe[0].rd : 5'd0;
        e.load_ex = pipe[0].valid && pipe[0].ld;
        e.rd_me   = pipe[1].valid ? pipe[1].rd : 5'd0;
        e.ruwr_me = pipe[1].valid && pipe[1].wr;
        e.rd_wb   = pipe[2].valid ? pipe[2].rd : 5'd0;
        e.ruwr_wb = pipe[2].valid && pipe[2].wr;
        e.cnt     = cnt_m;

        lu = 1'b0;
        if (v && pipe[0].valid && pipe[0].ld && pipe[0].wr && pipe[0].rd != 0) begin
            if (u1 && s1 == pipe[0].rd) lu = 1'b1;
            if (u2 && s2 == pipe[0].rd) lu = 1'b1;
        end

        if (r) begin
            e.freeze = 0; e.flush_de = 0; e.stall_de = 0; e.stall_fe = 0;
        end else begin
            e.freeze   = !mr;
            e.flush_de = br && mr;
            e.stall_de = lu && !br && mr;
            e.stall_fe = e.stall_de;
        end
        if (push) exp_q.push_back(e);

        if (r) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            cnt_m = 0;
        end else begin
            if (e.stall_de || e.freeze) begin
`ifdef HAZARD_STATS_EN
                if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
`endif
            end
            if (!e.freeze) begin
                nxt[2] = pipe[1];
                nxt[1] = pipe[0];
                if (e.flush_de || e.stall_de) nxt[0] = '{0, 0, 0, 0};
                else                          nxt[0] = '{v, d, w, l};
                pipe = nxt;
            end
        end
    endtask

    task automatic idle(input bit mr);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mr, 1);
    endtask

    // Monitor: every cycle this block samples the outputs 2 time units after
    // the inputs change, which is well before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall_fe", bus.stall_fe, e.stall_fe);
            chk("stall_de", bus.stall_de, e.stall_de);
            chk("flush_de", bus.flush_de, e.flush_de);
            chk("freeze",   bus.freeze,   e.freeze);
            chk("rd_ex",    bus.rd_ex,    e.rd_ex);
            chk("load_ex",  bus.load_ex,  e.load_ex);
            chk("rd_me",    bus.rd_me,    e.rd_me);
            chk("RUWr_me",  bus.RUWr_me,  e.ruwr_me);
            chk("rd_wb",    bus.rd_wb,    e.rd_wb);
            chk("RUWr_wb",  bus.RUWr_wb,  e.ruwr_wb);
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
        cnt_m = 0;

        // Reset for 2 cycles with random inputs. The state is unknown before
        // the first edge, so only the second cycle is checked.
        cycle(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        cycle(1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
        idle(1);

        // Flow-through: add x5
        cycle(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 1);
        repeat (4) idle(1);

        // Load-use: lw x10, then add reads x10 (held in decode for the stall)
        cycle(0, 1, 1, 0, 1, 0, 10, 1, 1, 0, 1, 1);
        cycle(0, 1, 3, 10, 1, 1, 11, 1, 0, 0, 1, 1);
        cycle(0, 1, 3, 10, 1, 1, 11, 1, 0, 0, 1, 1);
        repeat (3) idle(1);

        // Load to x0 followed by a use of x0: no stall
        cycle(0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1);
        cycle(0, 1, 0, 0, 1, 1, 6, 1, 0, 0, 1, 1);
        repeat (3) idle(1);

        // Flush wins over load-use
        cycle(0, 1, 1, 0, 1, 0, 12, 1, 1, 0, 1, 1);
        cycle(0, 1, 12, 0, 1, 0, 13, 1, 0, 1, 1, 1);
        repeat (3) idle(1);

        // Freeze with rd_me=7, rd_wb=3
        cycle(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 1);
        idle(1);
        repeat (3) idle(0);
        repeat (3) idle(1);

        // Freeze during a pending load-use stall
        cycle(0, 1, 1, 0, 1, 0, 9, 1, 1, 0, 1, 1);
        cycle(0, 1, 9, 0, 1, 0, 14, 1, 0, 0, 0, 1);
        cycle(0, 1, 9, 0, 1, 0, 14, 1, 0, 0, 0, 1);
        cycle(0, 1, 9, 0, 1, 0, 14, 1, 0, 0, 1, 1);
        cycle(0, 1, 9, 0, 1, 0, 14, 1, 0, 0, 1, 1);
        repeat (3) idle(1);

        // Back-to-back dependent loads
        cycle(0, 1, 1, 0, 1, 0, 4, 1, 1, 0, 1, 1);
        cycle(0, 1, 4, 0, 1, 0, 8, 1, 1, 0, 1, 1);
        cycle(0, 1, 4, 0, 1, 0, 8, 1, 1, 0, 1, 1);
        cycle(0, 1, 0, 8, 0, 1, 2, 1, 0, 0, 1, 1);
        cycle(0, 1, 0, 8, 0, 1, 2, 1, 0, 0, 1, 1);
        repeat (3) idle(1);

        // Random traffic. Small register indices make hazards frequent.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) != 0), 1);
        end

        idle(1);
        @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks destination registers in flight in the EX, ME and WB stages of the 5-stage RISC-V pipeline.
- Drives the rd_me/rd_wb/RUWr_me/RUWr_wb signals consumed by FU, the forwarding unit.
- Generates the hazards FU cannot resolve by bypassing: load-use stall, taken-branch flush and data-memory wait freeze.
- Sits beside the DE/EX/ME/WB pipeline registers; all hazard outputs go to the control of those registers.

Parameters:
REG_W, 5, register index width
CNT_W, 16, width of stall statistics counter (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
valid_de  in  1  decode holds a real instruction
rs1_de  in  REG_W  decode source 1 index
rs2_de  in  REG_W  decode source 2 index
rs1_use_de  in  1  decode instruction reads rs1
rs2_use_de  in  1  decode instruction reads rs2
rd_de  in  REG_W  decode destination index
RUWr_de  in  1  decode instruction writes register unit
load_de  in  1  decode instruction is a load
br_taken_ex  in  1  branch/jump resolved taken in EX
mem_ready  in  1  data memory completes access this cycle
stall_fe  out  1  hold PC / IF-DE register
stall_de  out  1  hold DE-EX inputs; insert bubble into EX
flush_de  out  1  kill instruction in IF-DE register
freeze  out  1  hold every pipeline register
rd_ex  out  REG_W  EX-stage destination
load_ex  out  1  EX-stage instruction is a load
rd_me  out  REG_W  ME-stage destination (to FU)
RUWr_me  out  1  ME-stage write enable (to FU)
rd_wb  out  REG_W  WB-stage destination (to FU)
RUWr_wb  out  1  WB-stage write enable (to FU)
stall_cnt  out  CNT_W  stall statistics (optional feature only)

Behaviour:
- State: three stage entries EX, ME, WB, each holding {valid, rd, RUWr, load}.
- Reset (synchronous, rst=1 at clk edge): all entries invalid, rd=0, RUWr=0, load=0. All outputs 0 in the cycle after reset. Reset wins over every other event, including mid-stall and mid-freeze.
- Entry outputs: RUWr_me/RUWr_wb = entry.valid & entry.RUWr. rd_* presents the entry rd (0 when invalid). Registered, so zero latency from state.
- Hazard outputs are combinational from state and inputs, valid in the same cycle.
- load_use = EX.valid & EX.load & EX.RUWr & EX.rd!=0 & valid_de & ((rs1_use_de & rs1_de==EX.rd) | (rs2_use_de & rs2_de==EX.rd)).
- Register x0 never causes a hazard.
- freeze = ~mem_ready. stall_fe = stall_de = load_use & ~br_taken_ex & ~freeze. flush_de = br_taken_ex & ~freeze.
- Priority: freeze > flush > load-use stall.
- Update at clk edge, rst=0:
  - freeze: EX, ME and WB all hold.
  - otherwise: WB<=ME and ME<=EX.
  - EX<=bubble (invalid) if flush_de or stall_de.
  - otherwise EX<={valid_de, rd_de, RUWr_de & valid_de, load_de & valid_de}.
- A load-use stall lasts exactly 1 cycle: the load moves to ME and load_use drops; FU then forwards from ME.
- Flush and load-use in the same cycle: flush wins, no stall, and EX receives a bubble.
- Back-to-back loads with dependence produce a stall per dependent pair, never more than 1 cycle each.
- A freeze during a stall keeps the stall condition pending. The stall asserts in the first cycle after mem_ready returns.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cnt is present. It is a saturating counter that increments on every cycle with stall_de=1 or freeze=1. It clears on rst and holds at all-ones.
- Undefined: the stall_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; after release, RUWr_me=RUWr_wb=0 until instructions flow.
- Flow-through: issue add x5 (RUWr=1, rd=5) with mem_ready=1 -> rd_ex=5 at +1, rd_me=5/RUWr_me=1 at +2, rd_wb=5/RUWr_wb=1 at +3; no stall at any point.
- Load-use: lw x10 then add with rs2_de=10, rs2_use_de=1 -> stall_fe=stall_de=1 for exactly 1 cycle; next cycle rd_me=10/RUWr_me=1 and EX invalid. Repeat with rd=0 -> no stall.
- Flush priority: load_use true and br_taken_ex=1 in the same cycle -> flush_de=1, stall_de=0, EX invalid the next cycle.
- Freeze: mem_ready=0 for 3 cycles while rd_me=7 and rd_wb=3 -> freeze=1, entries unchanged for 3 cycles, stall_de=0; after mem_ready=1 the pipeline advances one stage per cycle.
- Stats (HAZARD_STATS_EN): 1 load-use stall plus 3 freeze cycles -> stall_cnt=4. Force CNT_W=2 and run 6 stall cycles -> stall_cnt saturates at 3.
